// File: rtl/uart_pi1_drv.sv
// pi1 initiator driving a uart_hw-compatible responder: programs the line speed, then polls FIFO usage
// and moves bytes both ways. Define UART_PI1_DRV_INTR_EN to gate RX polling on intrqst_i.
module uart_pi1_drv #(
  parameter int ARCHBITSZ  = 32,
  parameter int BASEADDR   = 0,
  parameter int BUFSZ      = 2,
  parameter int CLKSPERBIT = 868,
  localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic [1:0]             pi1_op_o,
  output logic [ADDRBITSZ-1:0]   pi1_addr_o,
  output logic [ARCHBITSZ-1:0]   pi1_data_o,
  input  logic [ARCHBITSZ-1:0]   pi1_data_i,
  output logic [ARCHBITSZ/8-1:0] pi1_sel_o,
  input  logic                   pi1_rdy_i,
  input  logic                   tx_valid_i,
  input  logic [7:0]             tx_data_i,
  output logic                   tx_ready_o,
  output logic                   rx_valid_o,
  output logic [7:0]             rx_data_o,
  input  logic                   rx_ready_i,
`ifdef UART_PI1_DRV_INTR_EN
  input  logic                   intrqst_i,
`endif
  output logic                   cfg_done_o,
  output logic [ARCHBITSZ-1:0]   phyclkfreq_o
);

  localparam int UW = $clog2(BUFSZ) + 1;
  localparam logic [UW-1:0] BUFSZ_W = UW'(BUFSZ);

  localparam logic [1:0] OP_NOOP = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] OP_RW   = 2'b11;

  localparam logic [ARCHBITSZ-1:0] CMD_SPD = {2'd2, (ARCHBITSZ-2)'(CLKSPERBIT)};
  localparam logic [ARCHBITSZ-1:0] CMD_RXU = {2'd0, (ARCHBITSZ-2)'(0)};
  localparam logic [ARCHBITSZ-1:0] CMD_TXU = {2'd0, (ARCHBITSZ-2)'(1)};
  localparam logic [ARCHBITSZ-1:0] CMD_INT = {2'd1, (ARCHBITSZ-2)'(1)};

  typedef enum logic [3:0] {
    S_SPD, S_SPD_RSP, S_INT, S_PRX, S_PRX_RSP, S_RD, S_RD_RSP, S_PTX, S_PTX_RSP, S_WR
  } state_t;

  state_t                 state_q, state_d, round_st;
  logic [1:0]             op_q, op_d;
  logic [ARCHBITSZ-1:0]   data_q, data_d;
  logic [UW-1:0]          rx_avail_q, rx_avail_d;
  logic [UW-1:0]          tx_space_q, tx_space_d;
  logic                   rx_valid_q, rx_valid_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   cfg_done_q, cfg_done_d;
  logic [ARCHBITSZ-1:0]   phyclkfreq_q, phyclkfreq_d;
  logic [UW-1:0]          usage;
  logic                   accept;

  function automatic logic [UW-1:0] clamp_usage(input logic [UW-1:0] u);
    return (u > BUFSZ_W) ? BUFSZ_W : u;
  endfunction

  assign pi1_op_o     = op_q;
  assign pi1_data_o   = data_q;
  assign pi1_addr_o   = ADDRBITSZ'(BASEADDR);
  assign pi1_sel_o    = '1;
  assign rx_valid_o   = rx_valid_q;
  assign rx_data_o    = rx_data_q;
  assign cfg_done_o   = cfg_done_q;
  assign phyclkfreq_o = phyclkfreq_q;

  // Bus handshake: an op is taken at the edge where op != NOOP and pi1_rdy_i=1; op/data hold until
  // then, and any response is sampled one edge later in the *_RSP state. Each issue state spends one
  // cycle with op=NOOP loading the op; in WR that cycle also decides whether another byte follows.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    data_d       = data_q;
    rx_avail_d   = rx_avail_q;
    tx_space_d   = tx_space_q;
    rx_valid_d   = rx_valid_q;
    rx_data_d    = rx_data_q;
    cfg_done_d   = cfg_done_q;
    phyclkfreq_d = phyclkfreq_q;
    tx_ready_o   = 1'b0;
    usage        = clamp_usage(pi1_data_i[UW-1:0]);
    accept       = (op_q != OP_NOOP) && pi1_rdy_i;
`ifdef UART_PI1_DRV_INTR_EN
    round_st     = intrqst_i ? S_PRX : S_PTX;
`else
    round_st     = S_PRX;
`endif
    if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;

    case (state_q)
      S_SPD: begin
        if (op_q == OP_NOOP) begin op_d = OP_RW; data_d = CMD_SPD; end
        else if (accept) begin op_d = OP_NOOP; state_d = S_SPD_RSP; end
      end
      S_SPD_RSP: begin
        phyclkfreq_d = pi1_data_i;
        cfg_done_d   = 1'b1;
`ifdef UART_PI1_DRV_INTR_EN
        state_d      = S_INT;
`else
        state_d      = S_PRX;
`endif
      end
      S_INT: begin
        if (op_q == OP_NOOP) begin op_d = OP_RW; data_d = CMD_INT; end
        else if (accept) begin op_d = OP_NOOP; state_d = S_PTX; end
      end
      S_PRX: begin
        if (op_q == OP_NOOP) begin op_d = OP_RW; data_d = CMD_RXU; end
        else if (accept) begin op_d = OP_NOOP; state_d = S_PRX_RSP; end
      end
      S_PRX_RSP: begin
        rx_avail_d = usage;
        state_d    = (usage != '0 && !rx_valid_q) ? S_RD : S_PTX;
      end
      S_RD: begin
        if (op_q == OP_NOOP) op_d = OP_RD;
        else if (accept) begin op_d = OP_NOOP; state_d = S_RD_RSP; end
      end
      S_RD_RSP: begin
        rx_data_d  = pi1_data_i[7:0];
        rx_valid_d = 1'b1;
        rx_avail_d = (rx_avail_q != '0) ? rx_avail_q - UW'(1) : '0;
`ifdef UART_PI1_DRV_INTR_EN
        state_d    = (rx_avail_q <= UW'(1)) ? S_INT : S_PTX;
`else
        state_d    = S_PTX;
`endif
      end
      S_PTX: begin
        if (op_q == OP_NOOP) begin op_d = OP_RW; data_d = CMD_TXU; end
        else if (accept) begin op_d = OP_NOOP; state_d = S_PTX_RSP; end
      end
      S_PTX_RSP: begin
        tx_space_d = BUFSZ_W - usage;
        state_d    = (tx_valid_i && (BUFSZ_W - usage) != '0) ? S_WR : round_st;
      end
      S_WR: begin
        if (op_q == OP_NOOP) begin
          if (tx_valid_i && tx_space_q != '0) begin
            op_d   = OP_WR;
            data_d = {{(ARCHBITSZ-8){1'b0}}, tx_data_i};
          end else begin
            state_d = round_st;
          end
        end else if (accept) begin
          op_d       = OP_NOOP;
          tx_ready_o = 1'b1;
          tx_space_d = tx_space_q - UW'(1);
        end
      end
      default: begin
        op_d    = OP_NOOP;
        state_d = S_SPD;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_SPD;
      op_q         <= OP_NOOP;
      data_q       <= '0;
      rx_avail_q   <= '0;
      tx_space_q   <= '0;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= '0;
      cfg_done_q   <= 1'b0;
      phyclkfreq_q <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      data_q       <= data_d;
      rx_avail_q   <= rx_avail_d;
      tx_space_q   <= tx_space_d;
      rx_valid_q   <= rx_valid_d;
      rx_data_q    <= rx_data_d;
      cfg_done_q   <= cfg_done_d;
      phyclkfreq_q <= phyclkfreq_d;
    end
  end

endmodule

// File: doc/uart_pi1_drv.md
Name: uart_pi1_drv

Overview:
- pi1 initiator that owns a uart_hw-compatible pi1 responder.
- After reset it programs the line speed, then polls the device's buffer usage and moves bytes in both directions.
  - TX: local byte stream into the device TX FIFO.
  - RX: device RX FIFO out to a local byte stream.
- Sits between a local byte-stream client (console or loader logic) and the UART peripheral on a private pi1 link.

Parameters:
- ARCHBITSZ, 32: pi1 data width; ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ/8).
- BASEADDR, 0: word address of the UART device; driven on every op.
- BUFSZ, 2: device FIFO depth; must match the responder.
- CLKSPERBIT, 868: clock cycles per bit sent with CMDSETSPEED; must be nonzero and < 2^(ARCHBITSZ-2).

Ports:
- clk_i, input, 1: sole clock.
- rst_i, input, 1: reset, asynchronous and active-low.
- pi1_op_o, output, 2: 00 NOOP, 01 WR, 10 RD, 11 RW.
- pi1_addr_o, output, ADDRBITSZ: always BASEADDR.
- pi1_data_o, output, ARCHBITSZ: write data / command word.
- pi1_data_i, input, ARCHBITSZ: response data.
- pi1_sel_o, output, ARCHBITSZ/8: always all ones.
- pi1_rdy_i, input, 1: responder ready.
- tx_valid_i, input, 1: TX byte offered.
- tx_data_i, input, 8: TX byte.
- tx_ready_o, output, 1: TX byte consumed this cycle.
- rx_valid_o, output, 1: RX holding register full.
- rx_data_o, output, 8: RX byte.
- rx_ready_i, input, 1: client takes RX byte.
- cfg_done_o, output, 1: speed programmed.
- phyclkfreq_o, output, ARCHBITSZ: value returned by CMDSETSPEED.

Behaviour:
- Reset (rst_i=0, async) clears all outputs and state:
  - pi1_op_o=NOOP, pi1_data_o=0, tx_ready_o=0, rx_valid_o=0, rx_data_o=0, cfg_done_o=0, phyclkfreq_o=0.
  - Cached counts rx_avail=0, tx_space=0.
  - FSM enters SPD.
- Command word format: bits [ARCHBITSZ-1:ARCHBITSZ-2] = cmd (0 GETBUFFERUSAGE, 1 SETINTERRUPT, 2 SETSPEED); bits [ARCHBITSZ-3:0] = argument.
- pi1 handshake:
  - An op is accepted at the rising edge where pi1_op_o != NOOP and pi1_rdy_i=1.
  - op/data are held stable until accepted.
  - pi1_op_o returns to NOOP the cycle after acceptance.
  - For RD/RW, pi1_data_i is sampled at the first rising edge after acceptance (the RSP state). pi1_rdy_i is ignored in RSP.
- pi1_op_o and pi1_data_o are registered outputs.
- FSM states and transitions:
  - SPD: issue RW {2, CLKSPERBIT}. Accept -> SPD_RSP.
  - SPD_RSP: phyclkfreq_o <= pi1_data_i, cfg_done_o <= 1 -> PRX.
  - PRX: RW {0, arg=0}, i.e. RX usage. -> PRX_RSP.
  - PRX_RSP: rx_avail <= pi1_data_i[clog2(BUFSZ):0]. -> RD if rx_avail_new != 0 and !rx_valid_o, else PTX.
  - RD: issue RD. -> RD_RSP.
  - RD_RSP: rx_data_o <= pi1_data_i[7:0], rx_valid_o <= 1, rx_avail decrements. -> PTX (TX gets a turn after every RX byte).
  - PTX: RW {0, arg=1}, i.e. TX usage. -> PTX_RSP.
  - PTX_RSP: tx_space <= BUFSZ - usage. -> WR if tx_valid_i and tx_space_new != 0, else PRX.
  - WR: pi1_data_o = {0, tx_data_i}. On accept: tx_ready_o pulses 1 cycle, tx_space decrements. -> WR again if tx_space != 0 and tx_valid_i is still 1 next cycle, else PRX.
- Each WR consumes exactly one byte; tx_ready_o is high only in the acceptance cycle.
- Per-round ordering is fixed (TX poll always follows RX) so neither direction starves.
- RX holding register:
  - rx_valid_o clears when rx_valid_o and rx_ready_i are both 1.
  - No RD is issued while rx_valid_o=1, so the device FIFO supplies backpressure. RX data is never dropped.
- tx_data_i must stay stable while tx_valid_i=1 and tx_ready_o=0.
- Usage arithmetic is unsigned, width clog2(BUFSZ)+1. A usage value above BUFSZ is clamped to BUFSZ, giving tx_space=0.
- Reset asserted mid-op: the bus returns to NOOP immediately and the FSM restarts at SPD (speed is reprogrammed).

Optional Feature:
- Macro: UART_PI1_DRV_INTR_EN.
- Defined:
  - Adds input intrqst_i and a state INT after SPD_RSP that issues RW {1, 1} (threshold 1, response ignored).
  - PRX is entered only when intrqst_i=1; otherwise the FSM goes straight to PTX.
  - After RD_RSP empties rx_avail, INT is re-entered to re-arm the threshold before PTX.
- Undefined: no intrqst_i port; RX usage is polled every round.

Test Plan:
- Release reset with CLKSPERBIT=868 and the device model returning 100000000 -> first op is RW 0x80000364; cfg_done_o=1 and phyclkfreq_o=100000000 one cycle after the response.
- Device RX usage 2 with bytes 0x41, 0x42, rx_ready_i=1 -> two RD ops; rx_data_o shows 0x41 then 0x42; rx_avail=0; next PRX then PTX.
- rx_ready_i=0 with RX usage 2 -> one RD only; rx_valid_o stays 1 holding 0x41; no further RD until the byte is taken.
- tx_valid_i with 0x55, 0xAA, 0x0D, TX usage 0, BUFSZ=2 -> two WR ops (data 0x55, 0xAA), each with a one-cycle tx_ready_o pulse; 0x0D is sent only after a later PTX reports space.
- pi1_rdy_i held low 5 cycles during WR -> op and data held stable; exactly one tx_ready_o pulse at acceptance.
- Assert rst_i=0 during RD_RSP -> outputs reach reset values asynchronously; after release the first op is the SETSPEED RW.
